// File: rtl/signal_synth_if.sv
// Sample-stream bundle between the synthetic IF generator and a tracking channel.
// master: generator drives data/data_available/feed_complete/nav_req/chip_index, reads nav_bit.
// slave : channel/nav source reads the stream and supplies nav_bit.
interface signal_synth_if;
  logic [2:0] data;
  logic       data_available;
  logic       feed_complete;
  logic       nav_req;
  logic       nav_bit;
  logic [9:0] chip_index;

  modport master (
    output data, data_available, feed_complete, nav_req, chip_index,
    input  nav_bit
  );

  modport slave (
    input  data, data_available, feed_complete, nav_req, chip_index,
    output nav_bit
  );
endinterface

// File: rtl/signal_synth.sv
// Synthetic GPS L1 C/A IF sample generator: 3-bit carrier x (PRN ^ nav) samples, one every SAMPLE_DIV clocks.
// Ports: clk, global_reset (sync, active high), clear (sync restart), enable (run/freeze), prn_tap_a/b,
//        carrier_inc, code_inc; stream outputs and nav_bit on the ss interface. Outputs registered, 1 cycle after sample edge.
module signal_synth #(
  parameter int SAMPLE_DIV        = 4,
  parameter int CARRIER_ACC_WIDTH = 24,
  parameter int CODE_ACC_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         global_reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [3:0]                   prn_tap_a,
  input  logic [3:0]                   prn_tap_b,
  input  logic [CARRIER_ACC_WIDTH-1:0] carrier_inc,
  input  logic [CODE_ACC_WIDTH-1:0]    code_inc,
  signal_synth_if.master               ss
);
  localparam int              PC_W    = $clog2(SAMPLE_DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SAMPLE_DIV - 1);

  logic [PC_W-1:0]              pc_q, pc_d;
  logic [CARRIER_ACC_WIDTH-1:0] car_q, car_d;
  logic [CODE_ACC_WIDTH-1:0]    code_q, code_d;
  logic [9:0]                   chip_q, chip_d;
  logic [4:0]                   ms_q, ms_d;
  logic                         nav_cur_q, nav_cur_d;
  logic [10:1]                  g1_q, g1_d;
  logic [10:1]                  g2_q, g2_d;
  logic [2:0]                   data_q, data_d;
  logic                         dav_q, dav_d;
  logic                         fc_q, fc_d;
  logic                         nreq_q, nreq_d;

  logic                         sample_edge;
  logic [2:0]                   bin;
  logic                         ca_chip, neg, big;
  logic [2:0]                   sample;
  logic                         code_cy;
  logic [CODE_ACC_WIDTH-1:0]    code_sum;
  logic                         g1_fb, g2_fb;

  // G2 stage select; a tap outside 1..10 contributes 0.
  function automatic logic tap_sel(input logic [10:1] g, input logic [3:0] t);
    tap_sel = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (t == 4'(i)) tap_sel = g[i];
    end
  endfunction

  assign sample_edge = enable && (pc_q == PC_LAST);
  assign bin         = car_q[CARRIER_ACC_WIDTH-1 -: 3];
  assign ca_chip     = g1_q[10] ^ tap_sel(g2_q, prn_tap_a) ^ tap_sel(g2_q, prn_tap_b);
  // Carrier level is negative for bins 2..5 and has magnitude 3 for bins 0,3,4,7;
  // the code/nav symbol then flips the sign.
  assign neg         = (bin[2] ^ bin[1]) ^ (ca_chip ^ nav_cur_q);
  assign big         = ~(bin[1] ^ bin[0]);
  assign sample      = {neg, big ^ neg, 1'b1};
  assign {code_cy, code_sum} = {1'b0, code_q} + {1'b0, code_inc};
  assign g1_fb       = g1_q[3] ^ g1_q[10];
  assign g2_fb       = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];

  always_comb begin
    pc_d      = pc_q;
    car_d     = car_q;
    code_d    = code_q;
    chip_d    = chip_q;
    ms_d      = ms_q;
    nav_cur_d = nav_cur_q;
    g1_d      = g1_q;
    g2_d      = g2_q;
    data_d    = data_q;
    dav_d     = 1'b0;
    fc_d      = 1'b0;
    nreq_d    = 1'b0;

    if (enable) pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

    if (sample_edge) begin
      // Sample is formed from pre-advance state; all updates below land together.
      data_d = sample;
      dav_d  = 1'b1;
      car_d  = car_q + carrier_inc;
      code_d = code_sum;
      if (code_cy) begin
        if (chip_q == 10'd1022) begin
          chip_d = '0;
          g1_d   = '1;
          g2_d   = '1;
          fc_d   = 1'b1;
          if (ms_q == 5'd19) begin
            ms_d      = '0;
            nav_cur_d = ss.nav_bit;
            nreq_d    = 1'b1;
          end else begin
            ms_d = ms_q + 5'd1;
          end
        end else begin
          chip_d = chip_q + 10'd1;
          g1_d   = {g1_q[9:1], g1_fb};
          g2_d   = {g2_q[9:1], g2_fb};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset || clear) begin
      pc_q      <= '0;
      car_q     <= '0;
      code_q    <= '0;
      chip_q    <= '0;
      ms_q      <= '0;
      nav_cur_q <= 1'b0;
      g1_q      <= '1;
      g2_q      <= '1;
      data_q    <= '0;
      dav_q     <= 1'b0;
      fc_q      <= 1'b0;
      nreq_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      car_q     <= car_d;
      code_q    <= code_d;
      chip_q    <= chip_d;
      ms_q      <= ms_d;
      nav_cur_q <= nav_cur_d;
      g1_q      <= g1_d;
      g2_q      <= g2_d;
      data_q    <= data_d;
      dav_q     <= dav_d;
      fc_q      <= fc_d;
      nreq_q    <= nreq_d;
    end
  end

  assign ss.data           = data_q;
  assign ss.data_available = dav_q;
  assign ss.feed_complete  = fc_q;
  assign ss.nav_req        = nreq_q;
  assign ss.chip_index     = chip_q;
endmodule

// File: tb/tb_signal_synth.sv
// Bench for signal_synth: directed vector table plus hand-written freeze/clear/epoch/nav sequences.
// dut uses SAMPLE_DIV=4; dut2 (SAMPLE_DIV=2, one chip per sample) reaches the nav boundary quickly.
module tb_signal_synth;
  logic        clk = 1'b0;
  logic        global_reset, clear, enable;
  logic [3:0]  tap_a, tap_b;
  logic [23:0] car_inc;
  logic [31:0] code_inc, code_inc2;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  signal_synth_if bus();
  signal_synth_if bus2();

  signal_synth #(.SAMPLE_DIV(4), .CARRIER_ACC_WIDTH(24), .CODE_ACC_WIDTH(32)) dut (
    .clk(clk), .global_reset(global_reset), .clear(clear), .enable(enable),
    .prn_tap_a(tap_a), .prn_tap_b(tap_b), .carrier_inc(car_inc), .code_inc(code_inc),
    .ss(bus)
  );

  signal_synth #(.SAMPLE_DIV(2), .CARRIER_ACC_WIDTH(24), .CODE_ACC_WIDTH(32)) dut2 (
    .clk(clk), .global_reset(global_reset), .clear(clear), .enable(enable),
    .prn_tap_a(tap_a), .prn_tap_b(tap_b), .carrier_inc(car_inc), .code_inc(code_inc2),
    .ss(bus2)
  );

  typedef struct {
    bit          clr;
    logic [3:0]  ta;
    logic [3:0]  tb_;
    logic [23:0] ci;
    logic [31:0] ki;
    logic [2:0]  exp_data;
    int          exp_chip;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for the next strobe on dut; returns the number of cycles waited (0 on timeout).
  task automatic wait_strobe(input string name, output int cycles);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.data_available && n < 64);
    if (!bus.data_available) begin
      check({name, "_timeout"}, 1, 0);
      cycles = 0;
    end else begin
      cycles = n;
    end
  endtask

  function automatic logic [2:0] neg3(input logic [2:0] x);
    return 3'(~x + 3'd1);
  endfunction

  task automatic add(input bit c, input logic [3:0] a, input logic [3:0] b, input logic [23:0] ci,
                     input logic [31:0] ki, input logic [2:0] d, input int ch);
    vec_t v;
    v.clr = c; v.ta = a; v.tb_ = b; v.ci = ci; v.ki = ki; v.exp_data = d; v.exp_chip = ch;
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    logic [2:0] nav0_exp [10];
    logic [2:0] nav1_exp [10];
    nav0_exp = '{3'b101, 3'b101, 3'b011, 3'b011, 3'b101, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
    nav1_exp = '{3'b011, 3'b011, 3'b101, 3'b101, 3'b011, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};

    // PRN1 (taps 2,6), carrier 0, half a chip per sample
    add(1, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 0);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 1);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 1);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 2);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b011, 2);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b011, 3);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b011, 3);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b011, 4);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 4);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b101, 5);
    add(0, 4'd2, 4'd6, 24'd0, 32'h8000_0000, 3'b011, 5);
    // Carrier bins 0..7,0 with chip 1, nav 0: -3,-1,+1,+3,+3,+1,-1,-3,-3
    add(1, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b101, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b111, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b001, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b011, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b011, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b001, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b111, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b101, 0);
    add(0, 4'd2, 4'd6, 24'h20_0000, 32'd0, 3'b101, 0);
    // PRN2 (taps 3,7: 1110010...), one chip per sample after the first
    add(1, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b101, 0);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b101, 1);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b101, 2);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b101, 3);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b011, 4);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b011, 5);
    add(0, 4'd3, 4'd7, 24'd0, 32'hFFFF_FFFF, 3'b101, 6);
    // Tap 12 reads as 0: chip = G1[10] ^ G2[2] = 0,0,0,1
    add(1, 4'd12, 4'd2, 24'd0, 32'hFFFF_FFFF, 3'b011, 0);
    add(0, 4'd12, 4'd2, 24'd0, 32'hFFFF_FFFF, 3'b011, 1);
    add(0, 4'd12, 4'd2, 24'd0, 32'hFFFF_FFFF, 3'b011, 2);
    add(0, 4'd12, 4'd2, 24'd0, 32'hFFFF_FFFF, 3'b101, 3);

    // ---- reset values and strobe cadence ----
    global_reset = 1'b1; clear = 1'b0; enable = 1'b1;
    tap_a = 4'd2; tap_b = 4'd6; car_inc = 24'd0;
    code_inc = 32'h8000_0000; code_inc2 = 32'hFFFF_FFFF;
    bus.nav_bit = 1'b0; bus2.nav_bit = 1'b1;
    repeat (3) step();
    check("rst_data", bus.data, 0);
    check("rst_dav", bus.data_available, 0);
    check("rst_fc_nreq", {bus.feed_complete, bus.nav_req}, 0);
    check("rst_chip", bus.chip_index, 0);
    global_reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      // observation after edge k lies in cycle k+1; strobes expected in cycles 5, 9, 13
      check($sformatf("cadence_c%0d", k + 1), bus.data_available, ((k % 4) == 0) ? 1 : 0);
      if (k < 4) check($sformatf("pre_strobe_c%0d", k + 1),
                       {bus.data, bus.feed_complete, bus.nav_req, bus.chip_index}, 0);
    end

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      if (vecs[i].clr) begin
        tap_a = vecs[i].ta; tap_b = vecs[i].tb_;
        car_inc = vecs[i].ci; code_inc = vecs[i].ki;
        clear = 1'b1;
        step();
        clear = 1'b0;
      end
      wait_strobe($sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d_data", i), bus.data, vecs[i].exp_data);
      check($sformatf("vec%0d_chip", i), bus.chip_index, vecs[i].exp_chip);
    end

    // ---- freeze mid-sample ----
    tap_a = 4'd2; tap_b = 4'd6; car_inc = 24'd0; code_inc = 32'h8000_0000;
    clear = 1'b1; step(); clear = 1'b0;
    repeat (3) wait_strobe("frz_pre", cyc);
    check("frz_pre_data", bus.data, 3'b101);
    step();
    enable = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 7; k++) begin
        step();
        if (bus.data_available !== 1'b0 || bus.data !== 3'b101) bad++;
      end
      check("frz_quiet", bad, 0);
    end
    enable = 1'b1;
    wait_strobe("frz_s4", cyc);
    check("frz_resume_cycles", cyc, 3);
    check("frz_s4_data", bus.data, 3'b101);
    check("frz_s4_chip", bus.chip_index, 2);
    wait_strobe("frz_s5", cyc);
    check("frz_s5_data", bus.data, 3'b011);
    check("frz_s5_chip", bus.chip_index, 2);

    // ---- clear together with enable, mid-sample ----
    step(); step();
    clear = 1'b1;
    step();
    check("clr_data", bus.data, 0);
    check("clr_dav_fc_nreq", {bus.data_available, bus.feed_complete, bus.nav_req}, 0);
    check("clr_chip", bus.chip_index, 0);
    clear = 1'b0;
    wait_strobe("clr_s1", cyc);
    check("clr_first_cycles", cyc, 4);
    check("clr_s1_data", bus.data, 3'b101);
    repeat (3) wait_strobe("clr_s", cyc);
    check("clr_s4_chip", bus.chip_index, 2);
    wait_strobe("clr_s5", cyc);
    check("clr_s5_data", bus.data, 3'b011);

    // ---- epoch (dut) and nav boundary (dut2), run in parallel ----
    tap_a = 4'd2; tap_b = 4'd6; car_inc = 24'd0;
    code_inc = 32'h8000_0000; code_inc2 = 32'hFFFF_FFFF;
    global_reset = 1'b1; step(); step(); global_reset = 1'b0;
    fork
      begin : epoch_run
        int n = 0, c = 0, nfc = 0, fc1 = 0, fc2 = 0, nreq = 0, stray = 0;
        int chip2045 = -1, chip2046 = -1;
        while (n < 4100 && c < 20000) begin
          step();
          c++;
          if ((bus.feed_complete || bus.nav_req) && !bus.data_available) stray++;
          if (bus.data_available) begin
            n++;
            if (bus.nav_req) nreq++;
            if (bus.feed_complete) begin
              nfc++;
              if (nfc == 1) fc1 = n;
              if (nfc == 2) fc2 = n;
            end
            if (n == 2045) chip2045 = int'(bus.chip_index);
            if (n == 2046) chip2046 = int'(bus.chip_index);
          end
        end
        check("ep_samples", n, 4100);
        check("ep_fc_first", fc1, 2046);
        check("ep_fc_second", fc2, 4092);
        check("ep_fc_count", nfc, 2);
        check("ep_chip_2045", chip2045, 1022);
        check("ep_chip_2046", chip2046, 0);
        check("ep_no_nreq", nreq, 0);
        check("ep_stray", stray, 0);
      end
      begin : nav_run
        // code_inc2 = 2^32-1 carries on every sample from the 2nd on: epoch k on
        // sample 1024+1023*(k-1), so the 20th epoch (nav load) is sample 20461.
        int n = 0, c = 0, nfc = 0, nreq = 0, nreq_at = 0, nreq_fc = 0;
        logic [2:0] ref0 [10];
        logic [2:0] ref1 [10];
        logic [2:0] head [4];
        while (n < 20471 && c < 45000) begin
          step();
          c++;
          if (bus2.data_available) begin
            n++;
            if (n <= 4) head[n-1] = bus2.data;
            if (bus2.feed_complete) nfc++;
            if (bus2.nav_req) begin
              nreq++;
              nreq_at = n;
              nreq_fc = bus2.feed_complete;
            end
            if (n >= 1025 && n <= 1034) ref0[n-1025] = bus2.data;
            if (n >= 20462 && n <= 20471) ref1[n-20462] = bus2.data;
          end
        end
        check("nav_samples", n, 20471);
        check("nav_head", {head[0], head[1], head[2], head[3]}, {3'b101, 3'b101, 3'b101, 3'b011});
        check("nav_req_count", nreq, 1);
        check("nav_req_sample", nreq_at, 20461);
        check("nav_req_with_fc", nreq_fc, 1);
        check("nav_fc_count", nfc, 20);
        begin
          int bad0 = 0, bad1 = 0, badinv = 0;
          for (int i = 0; i < 10; i++) begin
            if (ref0[i] !== nav0_exp[i]) bad0++;
            if (ref1[i] !== nav1_exp[i]) bad1++;
            if (ref1[i] !== neg3(ref0[i])) badinv++;
          end
          check("nav0_epoch_samples", bad0, 0);
          check("nav1_epoch_samples", bad1, 0);
          check("nav_sign_inverted", badinv, 0);
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/signal_synth.md
# signal_synth

Synthetic GPS L1 C/A IF sample generator for closed-loop verification and in-system self-test of the tracking channels. It produces the sample stream that the subchannels consume on `data`, `data_available` and `feed_complete`. Each sample carries a quantized IF carrier modulated by a selectable PRN code and an externally supplied navigation bit. A programmable clock divider paces the output, and the block sits ahead of the channel sample feed as an alternate source to the front-end.

## Interface
- `SAMPLE_DIV`, default 4: clocks per output sample; must be ≥2.
- `CARRIER_ACC_WIDTH`, default 24: carrier phase accumulator width.
- `CODE_ACC_WIDTH`, default 32: code phase accumulator width.
- `clk`  in  1  system clock.
- `global_reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous restart of all generation state; `clear` wins over `enable`.
- `enable`  in  1  run/freeze control.
- `prn_tap_a`, `prn_tap_b`  in  4 each  G2 output taps (1..10) selecting the PRN, e.g. PRN1 = 2,6.
- `carrier_inc`  in  `CARRIER_ACC_WIDTH`  carrier phase increment per sample.
- `code_inc`  in  `CODE_ACC_WIDTH`  code phase increment per sample; accumulator overflow = one chip.
- `nav_bit`  in  1  next navigation bit, captured at a bit boundary.
- `data`  out  3  sample value, two's complement.
- `data_available`  out  1  one-cycle strobe: `data` is valid.
- `feed_complete`  out  1  high together with the last sample of each code period.
- `nav_req`  out  1  one-cycle pulse: `nav_bit` was just consumed.
- `chip_index`  out  10  current chip, 0..1022.

## Operation
- **Pacing counter** `pc`, range 0..`SAMPLE_DIV`-1, counts while `enable` is high. On a cycle where `pc`==`SAMPLE_DIV`-1 and `enable` is high (the *sample edge*):
  - `pc` resets to 0.
  - The output sample is registered.
  - All generator state advances.
- **Sample formation** uses pre-advance state:
  - Carrier bin b = top 3 bits of the carrier accumulator.
  - c(b) for b = 0..7 is +3, +1, -1, -3, -3, -1, +1, +3.
  - s = `ca_chip` XOR `nav_cur`.
  - `data` = s ? -c : +c. Encodings: +3 = 011, +1 = 001, -1 = 111, -3 = 101.
- **Carrier accumulator**: adds `carrier_inc` modulo 2^`CARRIER_ACC_WIDTH` on each sample edge.
- **Code accumulator**: adds `code_inc` modulo 2^`CODE_ACC_WIDTH` on each sample edge. A carry out causes a chip advance:
  - G1 and G2 shift.
  - `chip_index` increments.
  - When `chip_index` == 1022, it instead wraps to 0, both LFSRs reload all-ones, and an *epoch* occurs.
- **C/A generator**:
  - G1 is 1+x3+x10; G2 is 1+x2+x3+x6+x8+x9+x10. Both are 10-bit, with stage 1 as the input.
  - `ca_chip` = G1[10] ^ G2[`prn_tap_a`] ^ G2[`prn_tap_b`].
  - Taps outside 1..10 read as 0.
- **Navigation bit timing**:
  - An epoch counter `ms` runs 0..19. An epoch with `ms`==19 wraps `ms` to 0, loads `nav_cur` ← `nav_bit`, and pulses `nav_req`.
  - `nav_bit` must be stable at that edge; the source updates it after `nav_req`.
- **Feed complete**: `feed_complete` is asserted with the sample whose edge produces an epoch.
- **Enable low**: all state freezes, including `pc`. `data_available` stays 0. `data` holds its last value.
- **Reset / clear**: `global_reset` or `clear` returns the block to its reset state:
  - `pc` = 0, both accumulators = 0, `chip_index` = 0, `ms` = 0, `nav_cur` = 0, G1 = G2 = all-ones.
  - `data` = 000, `data_available` = 0, `feed_complete` = 0, `nav_req` = 0.
  - Mid-sample reset discards the pending sample.
- **Simultaneous events**: a chip carry, epoch and nav boundary on the same sample edge all take effect together. The emitted sample still uses the pre-advance chip and nav values.

## Timing
- Outputs are registered. `data_available`, `data`, `feed_complete` and `nav_req` are valid in the cycle after the sample edge.
- After reset release with `enable` held high, the first `data_available` appears in cycle `SAMPLE_DIV`+1 (cycle 1 is the first cycle after release). Thereafter strobes repeat every `SAMPLE_DIV` cycles.
- `code_inc` and `carrier_inc` are sampled at the sample edge. Changing them takes effect from the next sample.
- Tap changes take effect on the next sample; the LFSRs are not reloaded.

## Test plan
- **Reset values**: reset, then `enable`=1, `SAMPLE_DIV`=4. Check:
  - All outputs are 0 and `chip_index`=0 before the first strobe.
  - Strobes appear in cycles 5, 9, 13, ….
- **PRN1 code sequence**: taps 2,6, `carrier_inc`=0, `code_inc`=2^31, `nav_bit`=0.
  - Chips are 1,1,0,0,1,0,0,0,0,0, each held for two samples.
  - `data` = 101,101,101,101,011,011,011,011,101,101,011, ….
- **Carrier bins**: `code_inc`=0, `carrier_inc`=2^21 (24-bit) → `data` cycles -3,-1,+1,+3,+3,+1,-1,-3 (chip=1, nav=0).
- **Epoch and navigation boundary**: `code_inc`=2^31.
  - `feed_complete` is high on samples 2046, 4092, ….
  - `nav_req` pulses once every 40920 samples.
  - After `nav_bit`=1 is loaded, every following sample sign is inverted relative to the nav=0 run.
- **Freeze and clear**:
  - Drop `enable` for 7 cycles mid-sample: no strobe appears, and the stream resumes with no skipped or duplicated sample.
  - Assert `clear` together with `enable`: outputs return to reset values and the PRN sequence restarts at chip 0 (1,1,0,…).
